wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  - Writeback-end consumer of the EX/WB pipeline register in the 4-stage RV32I pipeline.
//  - Holds the 32x32 integer register file and commits rd/alu_result writes from EX/WB.
//  - Serves two combinational read ports to the ID stage and one debug read port.
//  - Counts committed writebacks for bring-up and performance checks.
// PARAMETERS
//  - XLEN      32           data width of every register
//  - SP_RESET  32'h0000_0FFC value loaded into x2 (sp) at reset; all other registers reset to 0
//  - CNT_W     32           width of wb_count
// PORTS
//  - clk             in   1      clock, rising edge
//  - reset           in   1      asynchronous, active-low
//  - reg_write_exwb  in   1      write enable from EX/WB
//  - rd_exwb         in   5      destination register index from EX/WB
//  - alu_result_exwb in   XLEN   writeback data from EX/WB
//  - rs1_addr        in   5      ID-stage source 1 index
//  - rs2_addr        in   5      ID-stage source 2 index
//  - rs1_data        out  XLEN   source 1 operand
//  - rs2_data        out  XLEN   source 2 operand
//  - dbg_addr        in   5      debug read index
//  - dbg_data        out  XLEN   debug read data (array contents only, never bypassed)
//  - wb_count        out  CNT_W  number of committed writes to x1..x31
// BEHAVIOUR
//  - Reset (reset==0, async): x1=0, x2=SP_RESET, x3..x31=0, wb_count=0.
//    Read outputs then reflect those values combinationally.
//  - Write: on posedge clk, a write commits when reset==1, reg_write_exwb==1 and rd_exwb!=0.
//    The commit stores alu_result_exwb into x[rd_exwb] and increments wb_count by 1.
//  - x0: always reads 0.
//  - A write with rd_exwb==0 is discarded; it changes no state and does not increment wb_count.
//  - Reads: rsN_data = x[rsN_addr] combinationally, with 0 latency.
//    If rsN_addr==0, rsN_data=0 regardless of bypass.
//  - Both read ports may address the same register. Each port resolves independently and
//    the two ports return identical data.
//  - wb_count wraps modulo 2**CNT_W with no saturation or flag.
//  - Reset asserted mid-operation: state clears immediately and asynchronously.
//    A write coincident with the deasserting edge is dropped; the first commit happens on
//    the first posedge with reset==1 sampled high.
//  - Undefined or X on rd_exwb while reg_write_exwb==0 has no effect.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined: write-first bypass.
//    When reg_write_exwb==1, rd_exwb!=0 and rd_exwb==rsN_addr, rsN_data=alu_result_exwb
//    in the same cycle. This removes the WB->ID hazard.
//  - REGFILE_BYPASS_EN undefined: read-old.
//    rsN_data returns the pre-commit array value; new data is visible the cycle after the edge.
//  - dbg_data is unaffected by the macro in both builds.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, REG_X0=5'd0, REG_SP=5'd2.
//  - Sub-module wb_bypass_mux:
//    - Inputs: array value, read addr, write enable/addr/data.
//    - Output: resolved operand, including the x0 zero rule.
//    - Instantiated twice (rs1, rs2); contains the REGFILE_BYPASS_EN ifdef.
//  - Storage: reg array x1..x31 only; x0 is not stored.
// TESTING
//  - Reset: hold reset=0, then release.
//    -> All rsN/dbg reads of x1..x31 return 0 except x2=32'h0000_0FFC; wb_count=0.
//  - Write x5=32'hDEAD_BEEF, then read rs1_addr=5 next cycle.
//    -> rs1_data=32'hDEAD_BEEF; wb_count=1.
//  - Write rd=0 with data 32'h1234_5678.
//    -> rs1_addr=0 gives 0; wb_count unchanged.
//  - Write x7=32'hA5A5_A5A5 while rs1_addr=rs2_addr=7 in the same cycle.
//    -> Bypass build: both ports read A5A5_A5A5 that cycle.
//    -> Non-bypass build: both read the old value, then A5A5_A5A5 after the edge.
//  - Assert reset between two back-to-back writes to x9.
//    -> x9=0 after reset; the write on the release edge is dropped; wb_count=0.
//  - Preload wb_count to 2**CNT_W-1 (force), then commit one write.
//    -> wb_count=0 and the write lands.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and types used by the writeback register file.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd2;

    localparam logic [XLEN-1:0] SP_RESET_DEFAULT = 32'h0000_0FFC;

    typedef logic [XLEN-1:0]       xdata_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Reset image of one architectural register: sp gets the stack top, all others clear.
    function automatic xdata_t f_reset_value(input reg_addr_t idx, input xdata_t sp_value);
        xdata_t v;
        if (idx == REG_SP) begin
            v = sp_value;
        end else begin
            v = {XLEN{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Read-port resolver: applies the x0 zero rule and, when REGFILE_BYPASS_EN is
// defined, forwards the in-flight writeback data (write-first); otherwise read-old.
module wb_bypass_mux
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]       i_array_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic [XLEN-1:0]       o_data
);

    logic w_hit;

    // Same-cycle hit on a committing write; x0 writes never forward.
    always_comb begin
        w_hit = 1'b0;
        if (i_we && (i_wr_addr != REG_X0) && (i_wr_addr == i_rd_addr)) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
    end

    // Operand select: x0 wins over everything.
    always_comb begin
        o_data = {XLEN{1'b0}};
        if (i_rd_addr == REG_X0) begin
            o_data = {XLEN{1'b0}};
        end else begin
`ifdef REGFILE_BYPASS_EN
            if (w_hit) begin
                o_data = i_wr_data;
            end else begin
                o_data = i_array_data;
            end
`else
            o_data = i_array_data;
`endif
        end
    end

    logic w_unused;
    assign w_unused = w_hit;

endmodule

// File: rtl/wb_regfile.sv
// Writeback register file for the 4-stage RV32I pipeline: 31 stored registers,
// two ID read ports, a debug port and a commit counter. Option macro: REGFILE_BYPASS_EN.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_exwb,
    input  logic [REG_ADDR_W-1:0] rd_exwb,
    input  logic [XLEN-1:0]       alu_result_exwb,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]       dbg_data,
    output logic [CNT_W-1:0]      wb_count
);

    logic [XLEN-1:0]  r_regs [1:NUM_REGS-1];
    logic [CNT_W-1:0] r_wb_count;

    logic             w_commit;
    logic [XLEN-1:0]  w_rs1_array;
    logic [XLEN-1:0]  w_rs2_array;
    logic [XLEN-1:0]  w_dbg_array;

    // Commit qualifier; rd is only looked at when the write enable is high.
    always_comb begin
        w_commit = 1'b0;
        if (reg_write_exwb) begin
            w_commit = (rd_exwb != REG_X0);
        end else begin
            w_commit = 1'b0;
        end
    end

    // Register array and commit counter; async clear loads the reset image.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= f_reset_value(REG_ADDR_W'(i), SP_RESET);
            end
            r_wb_count <= {CNT_W{1'b0}};
        end else if (w_commit) begin
            r_regs[rd_exwb] <= alu_result_exwb;
            r_wb_count      <= r_wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wb_count <= r_wb_count;
        end
    end

    // Raw array lookups; x0 is not stored and reads as zero.
    always_comb begin
        w_rs1_array = {XLEN{1'b0}};
        w_rs2_array = {XLEN{1'b0}};
        w_dbg_array = {XLEN{1'b0}};
        if (rs1_addr != REG_X0) begin
            w_rs1_array = r_regs[rs1_addr];
        end else begin
            w_rs1_array = {XLEN{1'b0}};
        end
        if (rs2_addr != REG_X0) begin
            w_rs2_array = r_regs[rs2_addr];
        end else begin
            w_rs2_array = {XLEN{1'b0}};
        end
        if (dbg_addr != REG_X0) begin
            w_dbg_array = r_regs[dbg_addr];
        end else begin
            w_dbg_array = {XLEN{1'b0}};
        end
    end

    wb_bypass_mux u_rs1_mux (
        .i_array_data (w_rs1_array),
        .i_rd_addr    (rs1_addr),
        .i_we         (w_commit),
        .i_wr_addr    (rd_exwb),
        .i_wr_data    (alu_result_exwb),
        .o_data       (rs1_data)
    );

    wb_bypass_mux u_rs2_mux (
        .i_array_data (w_rs2_array),
        .i_rd_addr    (rs2_addr),
        .i_we         (w_commit),
        .i_wr_addr    (rd_exwb),
        .i_wr_data    (alu_result_exwb),
        .o_data       (rs2_data)
    );

    assign dbg_data = w_dbg_array;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model of the architectural registers.
module tb_wb_regfile;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_exwb;
    logic [4:0]  rd_exwb;
    logic [31:0] alu_result_exwb;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wb_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_regs [32];
    logic [31:0] ref_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write_exwb  (reg_write_exwb),
        .rd_exwb         (rd_exwb),
        .alu_result_exwb (alu_result_exwb),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data),
        .wb_count        (wb_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_regs[2] = 32'h0000_0FFC;
        ref_cnt = 32'h0;
    endfunction

    // Architectural read as seen by the ID stage this cycle.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write_exwb === 1'b1 && rd_exwb != 5'd0 && rd_exwb == a) return alu_result_exwb;
`endif
        return ref_regs[a];
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, ".rs1"},   rs1_data, exp_read(rs1_addr));
        check({pfx, ".rs2"},   rs2_data, exp_read(rs2_addr));
        check({pfx, ".dbg"},   dbg_data, (dbg_addr == 5'd0) ? 32'h0 : ref_regs[dbg_addr]);
        check({pfx, ".count"}, wb_count, ref_cnt);
    endtask

    // One cycle: drive at negedge, check combinational outputs, then commit in the model.
    task automatic step(input string pfx, input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
        @(negedge clk);
        reg_write_exwb  = we;
        rd_exwb         = rd;
        alu_result_exwb = d;
        rs1_addr        = a1;
        rs2_addr        = a2;
        dbg_addr        = dbg;
        #1;
        check_outputs(pfx);
        @(posedge clk);
        if (reset && we && rd != 5'd0) begin
            ref_regs[rd] = d;
            ref_cnt      = ref_cnt + 32'd1;
        end
    endtask

    initial begin
        reset = 1'b0; reg_write_exwb = 1'b0; rd_exwb = 5'd0; alu_result_exwb = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        model_reset();

        // Reset image, during reset and after release.
        #12;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            check_outputs("reset_hold");
        end
        check("reset_sp", dbg_data, 32'h0);
        dbg_addr = 5'd2; #1;
        check("reset_sp_const", dbg_data, 32'h0000_0FFC);
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            check_outputs("reset_rel");
        end

        // Basic write then read.
        step("wr_x5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        step("rd_x5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check("x5_const", rs1_data, 32'hDEAD_BEEF);
        check("cnt1_const", wb_count, 32'd1);

        // Write to x0 is discarded.
        step("wr_x0", 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        step("rd_x0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("x0_zero", rs1_data, 32'h0);
        check("cnt_after_x0", wb_count, 32'd1);

        // Same-cycle read of the register being written, on both ports.
        step("pre_x7", 1'b1, 5'd7, 32'h1111_2222, 5'd0, 5'd0, 5'd0);
        step("wr_x7",  1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        check("x7_same_cycle", rs2_data, 32'hA5A5_A5A5);
`else
        check("x7_same_cycle", rs2_data, 32'h1111_2222);
`endif
        step("rd_x7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        check("x7_after", rs1_data, 32'hA5A5_A5A5);

        // Reset between back-to-back writes to x9.
        step("wr_x9a", 1'b1, 5'd9, 32'h0000_0009, 5'd9, 5'd0, 5'd9);
        @(negedge clk);
        reg_write_exwb = 1'b1; rd_exwb = 5'd9; alu_result_exwb = 32'h0000_0099;
        rs1_addr = 5'd9; dbg_addr = 5'd9;
        reset = 1'b0;
        model_reset();
        #1;
        check("x9_in_reset", dbg_data, 32'h0);
        check("cnt_in_reset", wb_count, 32'h0);
        @(negedge clk);
        reset = 1'b1; reg_write_exwb = 1'b0;
        #1;
        check("x9_after_reset", dbg_data, 32'h0);
        check("cnt_after_reset", wb_count, 32'h0);
        check_outputs("post_reset");
        step("wr_x9b", 1'b1, 5'd9, 32'h0000_0033, 5'd9, 5'd9, 5'd9);
        step("rd_x9b", 1'b0, 5'd0, 32'h0, 5'd9, 5'd2, 5'd9);

        // Counter wrap.
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        ref_cnt = 32'hFFFF_FFFF;
        check("cnt_preload", wb_count, 32'hFFFF_FFFF);
        step("wr_wrap", 1'b1, 5'd12, 32'hCAFE_F00D, 5'd0, 5'd0, 5'd0);
        step("rd_wrap", 1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd12);
        check("cnt_wrapped", wb_count, 32'h0);
        check("wrap_data", dbg_data, 32'hCAFE_F00D);

        // Randomized traffic, with forced address collisions for the bypass path.
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  rd, a1, a2, dbg;
            logic [31:0] d;
            we  = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            d   = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            dbg = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            step("rand", we, rd, d, a1, a2, dbg);
        end

        // Final sweep of the whole array through the debug port.
        @(negedge clk);
        reg_write_exwb = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); rs1_addr = 5'(i); rs2_addr = 5'(i);
            #1;
            check_outputs("sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
